ram_port_arb: RTL

- Arbitrates the single data/write port (port A) of the shared program/data RAM between two requesters.
- Requester 0 (C) is the core data path, i.e. the RAM side of the data-bus mux.
- Requester 1 (L) is the UART software-upgrade loader.
- Replaces the static upgrade-enable mux with a per-cycle arbiter. It adds a lock mode for exclusive upgrade, starvation protection for the core, and routing of 1-cycle-latency read data back to its owner.

---
 rtl/soc_pkg.sv | 18 +
 rtl/arb_burst_ctr.sv | 34 +++
 rtl/ram_port_arb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared types and defaults for the RAM port-A arbiter.
// Optional statistics counters are enabled with RAM_ARB_STATS_EN.
package soc_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        LOCK_PEND = 2'd1,
        LOCKED    = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_L = 1'b1
    } req_id_t;

    localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/arb_burst_ctr.sv
// Counts loader grants that the core sat through and flags when the core
// must be given the port to avoid starvation.
module arb_burst_ctr
    import soc_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rstb,
    input  logic c_req,
    input  logic grant_c,
    input  logic grant_l,
    input  logic clear,
    output logic starve
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    logic [3:0] burst_cnt;

    // The count only means "L wins while C waits", so any gap in c_req resets it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            burst_cnt <= '0;
        end else if (clear || grant_c || !c_req) begin
            burst_cnt <= '0;
        end else if (grant_l && (burst_cnt != MAX_CNT)) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    assign starve = c_req && (burst_cnt == MAX_CNT);

endmodule

// File: rtl/ram_port_arb.sv
// Per-cycle arbiter for RAM port A between the core (C) and the UART loader (L),
// with exclusive lock mode; RAM_ARB_STATS_EN adds grant/conflict counters.
module ram_port_arb
    import soc_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RAM_ADDR_LEN = 14,
    parameter int MAX_BURST    = DEFAULT_MAX_BURST
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    c_req,
    input  logic [XLEN/8-1:0]       c_we,
    input  logic [RAM_ADDR_LEN-1:0] c_addr,
    input  logic [XLEN-1:0]         c_wr_data,
    output logic                    c_ready,
    output logic                    c_rd_valid,
    output logic [XLEN-1:0]         c_rd_data,
    input  logic                    l_req,
    input  logic [XLEN/8-1:0]       l_we,
    input  logic [RAM_ADDR_LEN-1:0] l_addr,
    input  logic [XLEN-1:0]         l_wr_data,
    output logic                    l_ready,
    output logic                    l_rd_valid,
    output logic [XLEN-1:0]         l_rd_data,
    input  logic                    l_lock,
    output logic                    locked,
`ifdef RAM_ARB_STATS_EN
    input  logic                    stat_clr,
    output logic [15:0]             stat_c_grants,
    output logic [15:0]             stat_l_grants,
    output logic [15:0]             stat_conflicts,
`endif
    output logic                    ram_en,
    output logic [XLEN/8-1:0]       ram_we,
    output logic [RAM_ADDR_LEN-1:0] ram_addr,
    output logic [XLEN-1:0]         ram_wr_data,
    input  logic [XLEN-1:0]         ram_rd_data
);

    arb_state_t      state;
    req_id_t         rd_owner;
    logic            rd_pend;
    logic            grant_c;
    logic            grant_l;
    logic            starve;
    logic            unlock;
    logic            c_rd_inflight;
    logic            rd_issue;
    logic [XLEN-1:0] c_hold;
    logic [XLEN-1:0] l_hold;

    assign c_rd_inflight = rd_pend && (rd_owner == REQ_C);
    assign unlock        = (state != NORMAL) && !l_lock;

    arb_burst_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_ctr (
        .clk     (clk),
        .rstb    (rstb),
        .c_req   (c_req),
        .grant_c (grant_c),
        .grant_l (grant_l),
        .clear   (unlock),
        .starve  (starve)
    );

    // Grants are gated by rstb so the RAM port goes quiet the instant reset asserts.
    always_comb begin
        grant_c = 1'b0;
        grant_l = 1'b0;
        if (rstb) begin
            if (state == NORMAL) begin
                grant_c = c_req && (!l_req || starve);
                grant_l = l_req && !grant_c;
            end else begin
                grant_l = l_req;
            end
        end
    end

    assign c_ready  = grant_c;
    assign l_ready  = grant_l;
    assign ram_en   = grant_c || grant_l;
    assign rd_issue = ram_en && (ram_we == '0);

    always_comb begin
        ram_we      = '0;
        ram_addr    = '0;
        ram_wr_data = '0;
        if (grant_c) begin
            ram_we      = c_we;
            ram_addr    = c_addr;
            ram_wr_data = c_wr_data;
        end else if (grant_l) begin
            ram_we      = l_we;
            ram_addr    = l_addr;
            ram_wr_data = l_wr_data;
        end
    end

    // LOCK_PEND waits only for a core read already issued; new core grants are blocked.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= NORMAL;
            locked <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    locked <= 1'b0;
                    if (l_lock) state <= LOCK_PEND;
                end
                LOCK_PEND: begin
                    if (!l_lock) begin
                        state  <= NORMAL;
                        locked <= 1'b0;
                    end else if (!c_rd_inflight) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!l_lock) begin
                        state  <= NORMAL;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= NORMAL;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_pend  <= 1'b0;
            rd_owner <= REQ_C;
            c_hold   <= '0;
            l_hold   <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) rd_owner <= grant_l ? REQ_L : REQ_C;
            if (c_rd_valid) c_hold <= ram_rd_data;
            if (l_rd_valid) l_hold <= ram_rd_data;
        end
    end

    assign c_rd_valid = rd_pend && (rd_owner == REQ_C);
    assign l_rd_valid = rd_pend && (rd_owner == REQ_L);
    assign c_rd_data  = c_rd_valid ? ram_rd_data : c_hold;
    assign l_rd_data  = l_rd_valid ? ram_rd_data : l_hold;

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stat_c_grants  <= '0;
            stat_l_grants  <= '0;
            stat_conflicts <= '0;
        end else if (stat_clr) begin
            stat_c_grants  <= '0;
            stat_l_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant_c && (stat_c_grants != 16'hFFFF)) stat_c_grants <= stat_c_grants + 16'd1;
            if (grant_l && (stat_l_grants != 16'hFFFF)) stat_l_grants <= stat_l_grants + 16'd1;
            if (c_req && l_req && (stat_conflicts != 16'hFFFF))
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule
